dice_button_conditioner: RTL and testbench



---
 rtl/dice_button_conditioner_if.sv | 27 ++
 rtl/dice_button_conditioner.sv | 143 ++++++++++++++
 tb/tb_dice_button_conditioner.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dice_button_conditioner_if.sv
// Button bundle between the board pins and the dice game logic.
// The conditioner takes the slave side, the pin driver the master side.
interface dice_button_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_toggle;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_toggle
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_toggle
    );
endinterface

// File: rtl/dice_button_conditioner.sv
// Synchroniser, debouncer and press/release/toggle generator for the dice buttons.
// Define BTN_AUTOREPEAT_EN to build the hold-to-repeat press generator.
module dice_button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int CNT_W           = 20
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic                    clk,
    input  logic                    Reset,
    dice_button_conditioner_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] raw_norm;
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] differ;
    logic [N_BTN-1:0] done;
    logic [N_BTN-1:0] accept;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] fire;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] toggle_q;
    logic [CNT_W-1:0] cnt [N_BTN];

    // pressed is always 1 inside, whatever the board wiring
    assign raw_norm = bus.btn_raw ^ {N_BTN{ACTIVE_LOW}};

    // two-flop synchroniser; reset parks both stages at released
    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_norm;
            sync2 <= sync1;
        end
    end

    // a new level is accepted once it has disagreed for the full window
    always_comb begin
        differ = sync2 ^ stable;
        done   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            done[i] = (cnt[i] == CNT_LAST);
        end
        accept = differ & done;
        rise   = accept & ~stable;
        fall   = accept & stable;
    end

    // debounce counters; any agreeing cycle restarts the window
    always_ff @(posedge clk) begin
        if (Reset) begin
            stable <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!differ[i]) begin
                    cnt[i] <= '0;
                end else if (done[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                              REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] FIRST_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] NEXT_LAST  = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0] hold [N_BTN];
    logic [N_BTN-1:0]  repeating;

    // repeat fires after the initial delay, then at the repeat period
    always_comb begin
        fire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            fire[i] = stable[i] & ~accept[i] &
                      (hold[i] == (repeating[i] ? NEXT_LAST : FIRST_LAST));
        end
    end

    // hold counters run only while a button sits in the pressed state
    always_ff @(posedge clk) begin
        if (Reset) begin
            repeating <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!stable[i] || accept[i]) begin
                    hold[i]      <= '0;
                    repeating[i] <= 1'b0;
                end else if (fire[i]) begin
                    hold[i]      <= '0;
                    repeating[i] <= 1'b1;
                end else begin
                    hold[i] <= hold[i] + 1'b1;
                end
            end
        end
    end
`else
    assign fire = '0;
`endif

    // registered one-cycle pulses and the press-driven toggle
    always_ff @(posedge clk) begin
        if (Reset) begin
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
        end else begin
            press_q   <= rise | fire;
            release_q <= fall;
            toggle_q  <= toggle_q ^ (rise | fire);
        end
    end

    assign bus.btn_level   = stable;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_toggle  = toggle_q;
endmodule

// File: tb/tb_dice_button_conditioner.sv
// Bench for dice_button_conditioner: directed scenarios then random bouncing,
// each cycle compared with a window-based reference model.
module tb_dice_button_conditioner;
    localparam int NB = 3;
    localparam int D  = 8;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RD = 20;
    localparam int RP = 10;
`endif

    logic clk = 1'b0;
    logic Reset;

    dice_button_conditioner_if #(.N_BTN(NB)) bus ();

    dice_button_conditioner #(
        .N_BTN(NB),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW(1'b1),
        .CNT_W(4)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int seen_press   [NB];
    int seen_release [NB];

    logic [NB-1:0] exp_level;
    logic [NB-1:0] exp_press;
    logic [NB-1:0] exp_release;
    logic [NB-1:0] exp_toggle;
    bit            hist [NB][$];
    int            held [NB];

    // Model: the level becomes v once the last D samples that have passed
    // the two synchroniser stages all read v.
    task automatic model_edge(input logic [NB-1:0] raw, input logic rst);
        logic [NB-1:0] x;
        bit            same;
        x = ~raw;
        exp_press   = '0;
        exp_release = '0;
        if (rst) begin
            exp_level  = '0;
            exp_toggle = '0;
            for (int b = 0; b < NB; b++) begin
                hist[b].delete();
                hist[b].push_back(1'b0);
                hist[b].push_back(1'b0);
                held[b] = 0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                hist[b].push_back(x[b]);
                if (hist[b].size() > D + 2) void'(hist[b].pop_front());
                same = (hist[b].size() == D + 2);
                if (same) begin
                    for (int k = 1; k < D; k++) begin
                        if (hist[b][k] != hist[b][0]) same = 1'b0;
                    end
                end
                if (same && (hist[b][0] != exp_level[b])) begin
                    exp_level[b] = hist[b][0];
                    if (exp_level[b]) begin
                        exp_press[b]  = 1'b1;
                        exp_toggle[b] = ~exp_toggle[b];
                        held[b]       = 0;
                    end else begin
                        exp_release[b] = 1'b1;
                    end
                end else if (exp_level[b]) begin
                    held[b]++;
`ifdef BTN_AUTOREPEAT_EN
                    if (held[b] == RD ||
                        (held[b] > RD && (held[b] - RD) % RP == 0)) begin
                        exp_press[b]  = 1'b1;
                        exp_toggle[b] = ~exp_toggle[b];
                    end
`endif
                end
            end
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (bus.btn_level === exp_level) else begin
            miscompares++;
            $error("FAIL %s level got %b want %b", tag, bus.btn_level, exp_level);
        end
        assert (bus.btn_press === exp_press) else begin
            miscompares++;
            $error("FAIL %s press got %b want %b", tag, bus.btn_press, exp_press);
        end
        assert (bus.btn_release === exp_release) else begin
            miscompares++;
            $error("FAIL %s release got %b want %b", tag, bus.btn_release, exp_release);
        end
        assert (bus.btn_toggle === exp_toggle) else begin
            miscompares++;
            $error("FAIL %s toggle got %b want %b", tag, bus.btn_toggle, exp_toggle);
        end
        for (int b = 0; b < NB; b++) begin
            if (bus.btn_press[b] === 1'b1) seen_press[b]++;
            if (bus.btn_release[b] === 1'b1) seen_release[b]++;
        end
    endtask

    task automatic step(input logic [NB-1:0] raw, input logic rst, input string tag);
        bus.btn_raw = raw;
        Reset       = rst;
        @(posedge clk);
        model_edge(raw, rst);
        #1;
        check(tag);
    endtask

    task automatic hold_for(input logic [NB-1:0] raw, input int n, input string tag);
        for (int i = 0; i < n; i++) step(raw, 1'b0, tag);
    endtask

    task automatic count_check(input string tag, input int got, input int want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s count got %0d want %0d", tag, got, want);
        end
    endtask

    int            run  [NB];
    logic [NB-1:0] rraw;

    initial begin
        Reset       = 1'b1;
        bus.btn_raw = 3'b111;
        for (int b = 0; b < NB; b++) begin
            seen_press[b]   = 0;
            seen_release[b] = 0;
            run[b]          = 0;
        end

        for (int i = 0; i < 3; i++) step(3'b111, 1'b1, "reset");
        hold_for(3'b111, 20, "idle");
        count_check("idle_press0", seen_press[0], 0);

        hold_for(3'b110, 70, "press0");
        hold_for(3'b111, 15, "release0");

        seen_press[1] = 0;
        hold_for(3'b101, 5, "bounce1");
        hold_for(3'b111, 1, "bounce1");
        hold_for(3'b101, 5, "bounce1");
        hold_for(3'b111, 6, "bounce1");
        count_check("bounce_press1", seen_press[1], 0);
        hold_for(3'b101, 12, "held1");
        count_check("held_press1", seen_press[1], 1);
        seen_release[1] = 0;
        hold_for(3'b111, 15, "release1");
        count_check("release1", seen_release[1], 1);

        seen_release[2] = 0;
        hold_for(3'b011, 12, "press2a");
        hold_for(3'b111, 12, "release2a");
        hold_for(3'b011, 12, "press2b");
        hold_for(3'b111, 12, "release2b");
        count_check("release2", seen_release[2], 2);

        hold_for(3'b110, 7, "midcount");
        step(3'b110, 1'b1, "midreset");
        step(3'b110, 1'b1, "midreset");
        seen_press[0] = 0;
        hold_for(3'b110, 15, "held_after_reset");
        count_check("reset_press0", seen_press[0], 1);
        hold_for(3'b111, 15, "release_after_reset");

        rraw = 3'b111;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NB; b++) begin
                if (run[b] == 0) begin
                    rraw[b] = ~rraw[b];
                    run[b]  = ($urandom_range(0, 3) == 0) ?
                              int'($urandom_range(10, 60)) :
                              int'($urandom_range(1, 9));
                end else begin
                    run[b]--;
                end
            end
            step(rraw, ($urandom_range(0, 499) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
